// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-port sequencer.
//  - Bit positions inside the UART status register.
//  - Register offsets relative to the UART base address.
//  - State encoding of the sequencer FSM.
//  - Saturating 8-bit increment used by the error counter.
package uart_pkg;

    // Status register bit positions
    localparam int ST_RX_AVAIL = 2;
    localparam int ST_RX_ERR   = 1;
    localparam int ST_TX_READY = 0;

    // Register offsets from the UART base address
    localparam logic [15:0] REG_DATA   = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;
    localparam logic [15:0] REG_PARK   = 16'd2;

    // One bus access per state; the following state always parks the bus
    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_PWAIT,
        S_RXRD,
        S_RXCAP,
        S_TXWR,
        S_GUARD,
        S_ERRCLR
    } ctrl_state_e;

    // Increment that sticks at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: o_head always presents the oldest
// entry while o_empty is low, and i_pop simply retires it.
// Ports:
//  i_clk, i_rst_n      clock, asynchronous active-low reset (pointers only)
//  i_push, i_push_data write request and data; ignored while full
//  i_pop               retire the head entry; ignored while empty
//  o_head              current head entry
//  o_full, o_empty     occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers decide what is valid
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Bus-master sequencer that owns the UART register port. It polls the status
// register continuously, drains received bytes into an RX FIFO, feeds the
// transmitter from a TX FIFO and clears RX errors, so the core only sees
// ready/valid byte streams.
// Ports:
//  i_clk, i_rst_n                       clock, asynchronous active-low reset
//  i_tx_valid, o_tx_ready, i_tx_data    host -> TX FIFO stream
//  o_rx_valid, i_rx_ready, o_rx_data    RX FIFO -> host stream (show-ahead)
//  o_bus_we, o_bus_addr, o_bus_wdata    registered UART register-port strobes
//  i_bus_rdata                          UART read data, one cycle after address
//  o_err_cnt                            saturating RX error count
//  o_busy                               FSM active or TX bytes pending
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0400,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_GUARD  = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    input  logic [7:0]  i_tx_data,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    output logic [7:0]  o_rx_data,
    output logic        o_bus_we,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);

    localparam logic [15:0] ADDR_DATA   = BASE_ADDR + REG_DATA;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;
    localparam logic [15:0] ADDR_PARK   = BASE_ADDR + REG_PARK;

    // The IDLE cycle that always follows GUARD is the last quiet cycle, so
    // GUARD itself only spans TX_GUARD-1 cycles (never fewer than one)
    localparam logic [7:0] GUARD_LOAD = (TX_GUARD > 1) ? 8'(TX_GUARD - 1) : 8'd1;

    ctrl_state_e state_q, state_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;

    logic        tx_pop;
    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_push;
    logic        rx_full;
    logic        rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_tx_valid),
        .i_push_data (i_tx_data),
        .i_pop       (tx_pop),
        .o_head      (tx_head),
        .o_full      (tx_full),
        .o_empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (rx_push),
        .i_push_data (i_bus_rdata),
        .i_pop       (i_rx_ready),
        .o_head      (o_rx_data),
        .o_full      (rx_full),
        .o_empty     (rx_empty)
    );

    assign o_tx_ready  = !tx_full;
    assign o_rx_valid  = !rx_empty;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_busy      = (state_q != S_IDLE) || !tx_empty;

    // Bus strobes are decoded from the state being entered, so the registered
    // outputs line up with the state that owns the access. Anything not
    // explicitly driven parks the bus.
    always_comb begin
        state_d     = state_q;
        bus_we_d    = 1'b0;
        bus_addr_d  = ADDR_PARK;
        bus_wdata_d = 8'h00;
        err_cnt_d   = err_cnt_q;
        guard_cnt_d = guard_cnt_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d    = S_POLL;
                bus_addr_d = ADDR_STATUS;
            end
            S_POLL: begin
                state_d = S_PWAIT;
            end
            // Status arrives now; errors first, then RX ahead of TX so the
            // receiver is not overrun
            S_PWAIT: begin
                if (i_bus_rdata[ST_RX_ERR]) begin
                    state_d    = S_ERRCLR;
                    bus_we_d   = 1'b1;
                    bus_addr_d = ADDR_STATUS;
                    err_cnt_d  = sat_inc8(err_cnt_q);
                end else if (i_bus_rdata[ST_RX_AVAIL] && !rx_full) begin
                    state_d    = S_RXRD;
                    bus_addr_d = ADDR_DATA;
                end else if (i_bus_rdata[ST_TX_READY] && !tx_empty) begin
                    state_d     = S_TXWR;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = ADDR_DATA;
                    bus_wdata_d = tx_head;
                    tx_pop      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RXRD: begin
                state_d = S_RXCAP;
            end
            // Only the host can pop between the full check and this push,
            // so there is always room here
            S_RXCAP: begin
                rx_push = 1'b1;
                state_d = S_IDLE;
            end
            S_TXWR: begin
                state_d     = S_GUARD;
                guard_cnt_d = GUARD_LOAD;
            end
            // Hold off polling while the UART starts the frame and drops tx_ready
            S_GUARD: begin
                if (guard_cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            S_ERRCLR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single state register block; every bus output is a flop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= ADDR_PARK;
            bus_wdata_q <= 8'h00;
            err_cnt_q   <= 8'h00;
            guard_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            err_cnt_q   <= err_cnt_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with a small behavioural
// model of the UART register port (registered read data) and a bus monitor.
module tb_uart_fifo_ctrl;

   localparam logic [15:0] BASE = 16'h0400;
   localparam logic [15:0] STAT = 16'h0401;
   localparam logic [15:0] PARK = 16'h0402;

   logic        clk = 1'b0;
   logic        rstN;
   logic        txValid;
   logic        txReady;
   logic [7:0]  txData;
   logic        rxValid;
   logic        rxReady;
   logic [7:0]  rxData;
   logic        busWe;
   logic [15:0] busAddr;
   logic [7:0]  busWdata;
   logic [7:0]  busRdata = 8'h00;
   logic [7:0]  errCnt;
   logic        busy;

   logic [2:0]  stat;
   logic [7:0]  rxByte;

   int          total = 0;
   int          bad = 0;
   int          rdCnt = 0;
   int          wrCnt = 0;
   int          clrCnt = 0;
   logic [7:0]  lastWdata = 8'h00;
   byte         evQ[$];

   uart_fifo_ctrl #(
      .BASE_ADDR (BASE),
      .TX_DEPTH  (8),
      .RX_DEPTH  (8),
      .TX_GUARD  (3)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_tx_valid  (txValid),
      .o_tx_ready  (txReady),
      .i_tx_data   (txData),
      .o_rx_valid  (rxValid),
      .i_rx_ready  (rxReady),
      .o_rx_data   (rxData),
      .o_bus_we    (busWe),
      .o_bus_addr  (busAddr),
      .o_bus_wdata (busWdata),
      .i_bus_rdata (busRdata),
      .o_err_cnt   (errCnt),
      .o_busy      (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // UART slave model: read data is registered, one cycle behind the address
   always @(posedge clk) begin
      if (busAddr == STAT && !busWe) begin
         busRdata <= {5'b00000, stat};
      end else if (busAddr == BASE && !busWe) begin
         busRdata <= rxByte;
      end else begin
         busRdata <= 8'h00;
      end
   end

   // Bus monitor: tallies data reads, data writes and status clears
   always @(posedge clk) begin
      if (rstN) begin
         if (busAddr == BASE && !busWe) begin
            rdCnt <= rdCnt + 1;
            evQ.push_back(8'h52);
         end
         if (busAddr == BASE && busWe) begin
            wrCnt <= wrCnt + 1;
            lastWdata <= busWdata;
            evQ.push_back(8'h57);
         end
         if (busAddr == STAT && busWe) begin
            clrCnt <= clrCnt + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Wait for a status poll address cycle, present status s for that poll only
   task automatic applyStimulus(input logic [2:0] s, input logic [2:0] after);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busAddr == STAT && !busWe) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("poll_seen", 32'(seen), 32'd1);
      stat = s;
      @(negedge clk);
      stat = after;
   endtask

   initial begin
      int rdSnap;
      int wrSnap;
      int clrSnap;
      int evSnap;
      int parks;
      logic found;

      rstN = 1'b0;
      txValid = 1'b0;
      txData = 8'h00;
      rxReady = 1'b0;
      stat = 3'b000;
      rxByte = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_we", 32'(busWe), 32'd0);
      checkOutput("rst_addr", 32'(busAddr), 32'(PARK));
      checkOutput("rst_wdata", 32'(busWdata), 32'd0);
      checkOutput("rst_err", 32'(errCnt), 32'd0);
      checkOutput("rst_tx_ready", 32'(txReady), 32'd1);
      checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rstN = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single TX byte, then three quiet cycles before the next poll
      $display("[TB] test 1: tx write and guard");
      wrSnap = wrCnt;
      stat = 3'b001;
      txValid = 1'b1;
      txData = 8'h41;
      @(negedge clk);
      txValid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busWe && busAddr == BASE) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("t1_write_seen", 32'(found), 32'd1);
      checkOutput("t1_wdata", 32'(busWdata), 32'h41);
      parks = 0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busAddr == STAT && !busWe) begin
            found = 1'b1;
            break;
         end
         if (busAddr == PARK && !busWe) parks++;
      end
      checkOutput("t1_poll_after_guard", 32'(found), 32'd1);
      checkOutput("t1_guard_cycles", 32'(parks), 32'd3);
      repeat (20) @(negedge clk);
      checkOutput("t1_write_count", 32'(wrCnt - wrSnap), 32'd1);
      stat = 3'b000;

      // 2: one RX byte; valid appears 4 cycles after the poll address cycle
      $display("[TB] test 2: rx read latency");
      rdSnap = rdCnt;
      rxByte = 8'h5A;
      applyStimulus(3'b100, 3'b000);
      checkOutput("t2_pwait_parked", 32'(busAddr), 32'(PARK));
      @(negedge clk);
      checkOutput("t2_rxrd_addr", 32'(busAddr), 32'(BASE));
      checkOutput("t2_rxrd_we", 32'(busWe), 32'd0);
      @(negedge clk);
      checkOutput("t2_read_one_cycle", 32'(busAddr), 32'(PARK));
      checkOutput("t2_not_yet_valid", 32'(rxValid), 32'd0);
      @(negedge clk);
      checkOutput("t2_rx_valid", 32'(rxValid), 32'd1);
      checkOutput("t2_rx_data", 32'(rxData), 32'h5A);
      repeat (10) @(negedge clk);
      checkOutput("t2_read_count", 32'(rdCnt - rdSnap), 32'd1);

      // 3: RX and TX both pending -> read before write
      $display("[TB] test 3: rx priority");
      txValid = 1'b1;
      txData = 8'h77;
      @(negedge clk);
      txValid = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("t3_busy_pending_tx", 32'(busy), 32'd1);
      rxByte = 8'h33;
      evSnap = evQ.size();
      applyStimulus(3'b101, 3'b001);
      repeat (20) @(negedge clk);
      checkOutput("t3_event_count", 32'(evQ.size() - evSnap), 32'd2);
      if (evQ.size() >= evSnap + 2) begin
         checkOutput("t3_first_read", 32'(evQ[evSnap]), 32'h52);
         checkOutput("t3_then_write", 32'(evQ[evSnap+1]), 32'h57);
      end else begin
         checkOutput("t3_events_missing", 32'(evQ.size() - evSnap), 32'd2);
      end
      checkOutput("t3_wdata", 32'(lastWdata), 32'h77);
      stat = 3'b000;
      @(negedge clk);
      checkOutput("t3_head0", 32'(rxData), 32'h5A);
      rxReady = 1'b1;
      @(negedge clk);
      checkOutput("t3_head1", 32'(rxData), 32'h33);
      @(negedge clk);
      rxReady = 1'b0;
      checkOutput("t3_drained", 32'(rxValid), 32'd0);

      // 4: RX FIFO full backpressure, TX still served, pop releases one read
      $display("[TB] test 4: rx full");
      rdSnap = rdCnt;
      wrSnap = wrCnt;
      rxByte = 8'h80;
      stat = 3'b101;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rdCnt - rdSnap >= 8) break;
      end
      repeat (40) @(negedge clk);
      checkOutput("t4_reads_stop_at_full", 32'(rdCnt - rdSnap), 32'd8);
      txValid = 1'b1;
      txData = 8'h99;
      @(negedge clk);
      txValid = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("t4_tx_while_full", 32'(wrCnt - wrSnap), 32'd1);
      checkOutput("t4_tx_wdata", 32'(lastWdata), 32'h99);
      checkOutput("t4_still_no_read", 32'(rdCnt - rdSnap), 32'd8);
      rxByte = 8'hC9;
      checkOutput("t4_head", 32'(rxData), 32'h80);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("t4_one_more_read", 32'(rdCnt - rdSnap), 32'd9);
      stat = 3'b000;
      repeat (5) @(negedge clk);
      rxReady = 1'b1;
      repeat (7) @(negedge clk);
      rxReady = 1'b0;
      checkOutput("t4_tail_valid", 32'(rxValid), 32'd1);
      checkOutput("t4_tail_data", 32'(rxData), 32'hC9);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      checkOutput("t4_empty", 32'(rxValid), 32'd0);

      // 5: 300 error statuses, counter saturates
      $display("[TB] test 5: error clears");
      clrSnap = clrCnt;
      stat = 3'b010;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (clrCnt - clrSnap >= 254) break;
      end
      checkOutput("t5_err_at_254", 32'(errCnt), 32'hFE);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (clrCnt - clrSnap >= 300) break;
      end
      stat = 3'b000;
      repeat (20) @(negedge clk);
      checkOutput("t5_clear_count", 32'(clrCnt - clrSnap), 32'd300);
      checkOutput("t5_err_saturated", 32'(errCnt), 32'hFF);

      // 6: TX FIFO full, then reset during RXCAP
      $display("[TB] test 6: tx full and reset mid-transaction");
      txValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         txData = 8'(8'hE0 + i);
         @(negedge clk);
      end
      txValid = 1'b0;
      checkOutput("t6_tx_full", 32'(txReady), 32'd0);
      rxByte = 8'h11;
      applyStimulus(3'b100, 3'b000);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      checkOutput("t6_rst_we", 32'(busWe), 32'd0);
      checkOutput("t6_rst_addr", 32'(busAddr), 32'(PARK));
      checkOutput("t6_rst_err", 32'(errCnt), 32'd0);
      checkOutput("t6_rst_rx_valid", 32'(rxValid), 32'd0);
      checkOutput("t6_rst_tx_ready", 32'(txReady), 32'd1);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      wrSnap = wrCnt;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busAddr == STAT && !busWe) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("t6_polling_resumed", 32'(found), 32'd1);
      stat = 3'b001;
      repeat (20) @(negedge clk);
      checkOutput("t6_tx_bytes_lost", 32'(wrCnt - wrSnap), 32'd0);
      checkOutput("t6_rx_still_empty", 32'(rxValid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
